imem_arbiter: RTL and testbench
===============================

// Module: imem_arbiter
// PURPOSE
//  Shares the single-ported word-addressed instruction memory between the core fetch
//  port and the program-loader port (UART/host loader, accelerator firmware writes).
//  Per-cycle round-robin arbitration, optional loader lock that holds off fetch,
//  one-cycle synchronous read latency, and an out-of-range address error per requester.
// PARAMETERS
//  ADDR_W  10  memory word-address width (2**ADDR_W words)
//  DATA_W  32  data width
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset, asynchronous, active-high
//  f_req      in   1       fetch request (read only)
//  f_addr     in   32      fetch byte address
//  f_gnt      out  1       fetch request accepted this cycle
//  f_rvalid   out  1       fetch read data valid (1-cycle pulse)
//  f_rdata    out  DATA_W  fetch read data
//  f_err      out  1       with f_rvalid: address out of range
//  l_req      in   1       loader request
//  l_we       in   1       loader write (1) / read (0)
//  l_addr     in   32      loader byte address
//  l_wdata    in   DATA_W  loader write data
//  l_lock     in   1       loader lock: fetch never granted while high
//  l_gnt      out  1       loader request accepted this cycle
//  l_rvalid   out  1       loader read data / write ack valid (1-cycle pulse)
//  l_rdata    out  DATA_W  loader read data (0 on write ack)
//  l_err      out  1       with l_rvalid: address out of range
//  m_en       out  1       memory enable
//  m_we       out  1       memory write enable
//  m_addr     out  ADDR_W  memory word address = granted addr[ADDR_W+1:2]
//  m_wdata    out  DATA_W  memory write data
//  m_rdata    in   DATA_W  memory read data, valid cycle after m_en & ~m_we
// BEHAVIOUR
//  - Reset: all outputs 0; rr_last=LOADER (fetch wins first contention); resp_owner=NONE.
//  - Request held by requester until gnt; accepted on rising clk with req & gnt.
//  - gnt combinational from req, l_lock, rr_last; at most one gnt per cycle.
//  - Only f_req: f_gnt=~l_lock. Only l_req: l_gnt=1. Both: l_lock -> loader;
//    else grant the one != rr_last. rr_last updates to the granted side on every grant.
//  - Range check: addr[31:ADDR_W+2]!=0 -> out of range; still granted, m_en=0,
//    response next cycle with rdata=0, err=1. Byte offset addr[1:0] ignored.
//  - In range: m_en=1, m_we=l_we&l_gnt, m_addr/m_wdata from granted side, same cycle.
//  - Response register resp_owner {NONE,FETCH,LOADER}, resp_err: set on grant edge;
//    next cycle drives exactly one rvalid; rdata=m_rdata for reads, 0 for writes/errors.
//  - Back-to-back grants every cycle allowed; throughput 1 access/cycle.
//  - l_lock rising while fetch response pending: response still delivered.
//  - rst asserted mid-operation: pending response dropped, no rvalid after release.
//  - Non-granted rdata outputs held at 0 (no stale data when rvalid=0).
// STRUCTURE
//  - Shared package imem_pkg: localparams OWNER_NONE/FETCH/LOADER (2-bit), ADDR_W default.
//  - Single module; arbitration combinational block + response-tracking registers.
//  - No sub-module; memory array stays in the existing instruction memory block.
// TESTING
//  - Reset: rst=1 mid-stream -> all outputs 0, rr_last=LOADER, no rvalid after release.
//  - Fetch only, f_addr=0x4, mem[1]=0x0062F433 -> f_gnt same cycle, f_rvalid next, f_rdata=0x0062F433.
//  - Contention, both req 4 cycles, l_lock=0 -> grants F,L,F,L; rvalids alternate 1 cycle later.
//  - l_lock=1, loader writes 0xDEADBEEF to 0x8, f_req=1 -> f_gnt=0 throughout,
//    l_rvalid ack l_rdata=0; lock drop + fetch 0x8 -> f_rdata=0xDEADBEEF.
//  - f_addr=0x00001000 (ADDR_W=10) -> f_gnt=1, m_en=0, next cycle f_rvalid=1, f_err=1, f_rdata=0.
//  - Back-to-back loader reads 0x0,0x4 every cycle -> two consecutive l_rvalid with matching data.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter.
//   IMEM_ADDR_W / IMEM_DATA_W : default memory word-address and data widths
//   OWNER_*                   : encoding of who owns the pending response slot
//   owner_t                   : 2-bit owner code type
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W = 10;
  localparam int unsigned IMEM_DATA_W = 32;

  typedef logic [1:0] owner_t;

  localparam owner_t OWNER_NONE   = 2'd0;
  localparam owner_t OWNER_FETCH  = 2'd1;
  localparam owner_t OWNER_LOADER = 2'd2;

endpackage

// File: rtl/imem_arbiter.sv
// Arbitrates the single-ported instruction memory between the core fetch port
// and the program-loader port, with round-robin fairness, a loader lock that
// holds off fetch, one-cycle read latency and per-requester range errors.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   f_req/f_addr               fetch request (read only), byte address
//   f_gnt/f_rvalid/f_rdata/f_err   fetch grant and response
//   l_req/l_we/l_addr/l_wdata  loader request, write enable, byte address, data
//   l_lock                     loader lock; fetch never granted while high
//   l_gnt/l_rvalid/l_rdata/l_err   loader grant and response (write ack: rdata 0)
//   m_en/m_we/m_addr/m_wdata   memory command, same cycle as the grant
//   m_rdata                    memory read data, valid the cycle after a read
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_err,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  owner_t      rr_last;
  owner_t      resp_owner;
  logic        resp_err;
  logic        resp_we;

  logic [31:0] g_addr;
  logic        g_any;
  logic        g_oor;
  logic        unused_ok;

  // Grant decision: lock forces loader, otherwise the side that did not win last.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!rst) begin
      if (f_req && l_req) begin
        if (l_lock || (rr_last == OWNER_FETCH)) begin
          l_gnt = 1'b1;
        end else begin
          f_gnt = 1'b1;
        end
      end else if (f_req) begin
        f_gnt = ~l_lock;
      end else if (l_req) begin
        l_gnt = 1'b1;
      end
    end
  end

  // Memory command from the granted side; out-of-range accesses never reach memory.
  always_comb begin
    g_addr  = l_gnt ? l_addr : f_addr;
    g_any   = f_gnt | l_gnt;
    g_oor   = |g_addr[31:ADDR_W+2];
    m_en    = g_any & ~g_oor;
    m_we    = l_gnt & l_we & ~g_oor;
    m_addr  = g_any ? g_addr[ADDR_W+1:2] : '0;
    m_wdata = l_gnt ? l_wdata : '0;
  end

  // Byte offset within a word is intentionally ignored.
  assign unused_ok = ^g_addr[1:0];

  // Round-robin history and the single outstanding response slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last    <= OWNER_LOADER;
      resp_owner <= OWNER_NONE;
      resp_err   <= 1'b0;
      resp_we    <= 1'b0;
    end else begin
      if (l_gnt) begin
        rr_last    <= OWNER_LOADER;
        resp_owner <= OWNER_LOADER;
        resp_err   <= g_oor;
        resp_we    <= l_we;
      end else if (f_gnt) begin
        rr_last    <= OWNER_FETCH;
        resp_owner <= OWNER_FETCH;
        resp_err   <= g_oor;
        resp_we    <= 1'b0;
      end else begin
        resp_owner <= OWNER_NONE;
        resp_err   <= 1'b0;
        resp_we    <= 1'b0;
      end
    end
  end

  // Response: rdata only passes memory data for an in-range read owned by that side.
  always_comb begin
    f_rvalid = (resp_owner == OWNER_FETCH);
    l_rvalid = (resp_owner == OWNER_LOADER);
    f_err    = f_rvalid & resp_err;
    l_err    = l_rvalid & resp_err;
    f_rdata  = (f_rvalid && !resp_err) ? m_rdata : '0;
    l_rdata  = (l_rvalid && !resp_err && !resp_we) ? m_rdata : '0;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed scoreboard bench for imem_arbiter with a behavioural synchronous memory.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, l_req, l_we, l_lock;
  logic [31:0] f_addr, l_addr, l_wdata;
  logic        f_gnt, f_rvalid, f_err, l_gnt, l_rvalid, l_err;
  logic [31:0] f_rdata, l_rdata;
  logic        m_en, m_we;
  logic [9:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t fq[$];
  resp_t lq[$];

  logic [31:0] mem [1024];

  always #5 clk = ~clk;

  imem_arbiter dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .l_err(l_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  // Synchronous single-port memory; read data holds until the next read.
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One request cycle: drive, check grants and memory command, queue expected response.
  task automatic step(input string nm, input logic fr, input logic [31:0] fa,
                      input logic lr, input logic lw, input logic [31:0] la,
                      input logic [31:0] ld, input logic lk,
                      input logic efg, input logic elg, input logic [31:0] edat);
    logic [31:0] ga;
    logic        oor, any;
    @(posedge clk); #1;
    f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_addr = la; l_wdata = ld; l_lock = lk;
    @(negedge clk);
    ga  = elg ? la : fa;
    oor = (ga[31:12] != 20'h0);
    any = efg | elg;
    chk({nm, " f_gnt"}, 32'(f_gnt), 32'(efg));
    chk({nm, " l_gnt"}, 32'(l_gnt), 32'(elg));
    chk({nm, " m_en"}, 32'(m_en), 32'(any & ~oor));
    chk({nm, " m_we"}, 32'(m_we), 32'(elg & lw & ~oor));
    if (any && !oor) chk({nm, " m_addr"}, 32'(m_addr), 32'(ga[11:2]));
    if (elg && lw && !oor) chk({nm, " m_wdata"}, m_wdata, ld);
    if (efg) fq.push_back('{data: edat, err: oor});
    if (elg) lq.push_back('{data: edat, err: oor});
  endtask

  task automatic idle(input string nm);
    step(nm, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Monitor: every response must match the oldest queued expectation.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (f_rvalid) begin
        if (fq.size() == 0) begin
          checks++; errors++;
          $display("FAIL f_rvalid unexpected: got 1 expected 0");
        end else begin
          r = fq.pop_front();
          chk("f_rdata", f_rdata, r.data);
          chk("f_err", 32'(f_err), 32'(r.err));
        end
      end else begin
        chk("f_rdata idle", f_rdata, 32'h0);
        chk("f_err idle", 32'(f_err), 32'h0);
      end
      if (l_rvalid) begin
        if (lq.size() == 0) begin
          checks++; errors++;
          $display("FAIL l_rvalid unexpected: got 1 expected 0");
        end else begin
          r = lq.pop_front();
          chk("l_rdata", l_rdata, r.data);
          chk("l_err", 32'(l_err), 32'(r.err));
        end
      end else begin
        chk("l_rdata idle", l_rdata, 32'h0);
        chk("l_err idle", 32'(l_err), 32'h0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'h11111111;
    mem[1] = 32'h0062F433;
    mem[2] = 32'h22222222;
    m_rdata = 32'h0;
    rst = 1'b1;
    f_req = 1'b0; f_addr = 32'h0; l_req = 1'b0; l_we = 1'b0;
    l_addr = 32'h0; l_wdata = 32'h0; l_lock = 1'b0;

    // Reset: outputs quiet even with both requesting.
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 32'h4; l_req = 1'b1; l_addr = 32'h8; l_wdata = 32'hFFFF_FFFF; l_we = 1'b1;
    @(negedge clk);
    chk("rst f_gnt", 32'(f_gnt), 32'h0);
    chk("rst l_gnt", 32'(l_gnt), 32'h0);
    chk("rst m_en", 32'(m_en), 32'h0);
    chk("rst m_we", 32'(m_we), 32'h0);
    chk("rst m_addr", 32'(m_addr), 32'h0);
    chk("rst f_rvalid", 32'(f_rvalid), 32'h0);
    chk("rst l_rvalid", 32'(l_rvalid), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;

    // Contention from reset: fetch first, then alternate.
    step("cont0", 1, 32'h0, 1, 0, 32'h4, 32'h0, 0, 1, 0, 32'h11111111);
    step("cont1", 1, 32'h0, 1, 0, 32'h4, 32'h0, 0, 0, 1, 32'h0062F433);
    step("cont2", 1, 32'h0, 1, 0, 32'h4, 32'h0, 0, 1, 0, 32'h11111111);
    step("cont3", 1, 32'h0, 1, 0, 32'h4, 32'h0, 0, 0, 1, 32'h0062F433);

    // Fetch only; byte offset ignored.
    step("fetch4", 1, 32'h4, 0, 0, 32'h0, 32'h0, 0, 1, 0, 32'h0062F433);
    step("fetch7", 1, 32'h7, 0, 0, 32'h0, 32'h0, 0, 1, 0, 32'h0062F433);

    // Fetch response pending while lock rises; locked loader write; unlock and read back.
    step("fpend", 1, 32'h8, 0, 0, 32'h0, 32'h0, 0, 1, 0, 32'h22222222);
    step("lockwr", 1, 32'h8, 1, 1, 32'h8, 32'hDEADBEEF, 1, 0, 1, 32'h0);
    step("lockhold", 1, 32'h8, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h0);
    step("unlock", 1, 32'h8, 0, 0, 32'h0, 32'h0, 0, 1, 0, 32'hDEADBEEF);

    // Out-of-range accesses for both sides.
    step("foor", 1, 32'h00001000, 0, 0, 32'h0, 32'h0, 0, 1, 0, 32'h0);
    step("loor", 0, 32'h0, 1, 1, 32'h80000000, 32'h12345678, 0, 0, 1, 32'h0);
    step("lroor", 0, 32'h0, 1, 0, 32'h00001004, 32'h0, 0, 0, 1, 32'h0);

    // Highest in-range word.
    step("lwmax", 0, 32'h0, 1, 1, 32'h00000FFC, 32'hA5A5A5A5, 0, 0, 1, 32'h0);
    step("fmax", 1, 32'h00000FFC, 0, 0, 32'h0, 32'h0, 0, 1, 0, 32'hA5A5A5A5);

    // Back-to-back loader reads.
    step("lb0", 0, 32'h0, 1, 0, 32'h0, 32'h0, 0, 0, 1, 32'h11111111);
    step("lb1", 0, 32'h0, 1, 0, 32'h4, 32'h0, 0, 0, 1, 32'h0062F433);
    idle("idle0");

    // Reset during a granted fetch: response must be dropped.
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 32'h4;
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mrst f_gnt", 32'(f_gnt), 32'h0);
    chk("mrst m_en", 32'(m_en), 32'h0);
    chk("mrst f_rvalid", 32'(f_rvalid), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; f_req = 1'b0;
    idle("post_rst0");
    idle("post_rst1");

    // After reset the fetch side wins the first contention again.
    step("rrpost", 1, 32'h0, 1, 0, 32'h4, 32'h0, 0, 1, 0, 32'h11111111);
    idle("idle1");

    // Drain outstanding expectations within a bounded number of cycles.
    for (int i = 0; i < 8 && (fq.size() != 0 || lq.size() != 0); i++) @(negedge clk);
    checks++;
    if (fq.size() != 0 || lq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", fq.size(), lq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
